// File: rtl/kbd_translator_pkg.sv
// Shared types, virtual-key constants and the default scan-to-ASCII table
// (the arom.mem image: lower half unshifted, upper half shifted).
package kbd_translator_pkg;

  typedef struct packed {
    logic       is_break;
    logic [7:0] vk;
  } kbd_event_t;

  typedef struct packed {
    logic caps;
    logic alt;
    logic ctrl;
    logic shift;
  } kbd_mods_t;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    EMIT
  } kbd_state_e;

  localparam logic [7:0] VK_LSHIFT = 8'hA0;
  localparam logic [7:0] VK_RSHIFT = 8'hA1;
  localparam logic [7:0] VK_LCTRL  = 8'hA2;
  localparam logic [7:0] VK_RCTRL  = 8'hA3;
  localparam logic [7:0] VK_LALT   = 8'hA4;
  localparam logic [7:0] VK_RALT   = 8'hA5;
  localparam logic [7:0] VK_CAPS   = 8'h14;
  localparam logic [7:0] VK_A      = 8'h41;
  localparam logic [7:0] VK_Z      = 8'h5A;

  localparam int ROM_DEPTH = 512;
  typedef logic [ROM_DEPTH-1:0][7:0] arom_t;

  // Shifted symbols for digit keys '0'..'9', leftmost character is '0'.
  localparam logic [79:0] SHIFT_DIGITS = ")!@#$%^&*(";

  function automatic logic is_letter(input logic [7:0] vk);
    return (vk >= VK_A) && (vk <= VK_Z);
  endfunction

  function automatic logic is_modifier(input logic [7:0] vk);
    return (vk >= VK_LSHIFT && vk <= VK_RALT) || (vk == VK_CAPS);
  endfunction

  function automatic arom_t arom_table();
    arom_t      t;
    logic [8:0] a;
    t = '0;
    for (int v = 0; v < 256; v++) begin
      a = 9'(v);
      if (a[7:0] >= VK_A && a[7:0] <= VK_Z) begin
        t[a]                = a[7:0] + 8'h20;
        t[{1'b1, a[7:0]}]   = a[7:0];
      end else if (a[7:0] >= 8'h30 && a[7:0] <= 8'h39) begin
        t[a]                = a[7:0];
        t[{1'b1, a[7:0]}]   = SHIFT_DIGITS[8*(8'h39 - a[7:0]) +: 8];
      end
    end
    t[9'h008] = 8'h08;  t[9'h108] = 8'h08;
    t[9'h009] = 8'h09;  t[9'h109] = 8'h09;
    t[9'h00D] = 8'h0D;  t[9'h10D] = 8'h0D;
    t[9'h01B] = 8'h1B;  t[9'h11B] = 8'h1B;
    t[9'h020] = 8'h20;  t[9'h120] = 8'h20;
    return t;
  endfunction

endpackage

// File: rtl/kbd_translator_ascii_rom.sv
// Registered-read 512x8 scan-to-ASCII table addressed by {shift, vk}.
// CONTENTS defaults to the arom.mem image built in kbd_translator_pkg.
module kbd_translator_ascii_rom
  import kbd_translator_pkg::*;
#(
  parameter arom_t CONTENTS = arom_table()
) (
  input  logic       clk_i,
  input  logic       read_enable_i,
  input  logic [8:0] read_addr_i,
  output logic [7:0] read_data_o
);

  always_ff @(posedge clk_i) begin
    if (read_enable_i) read_data_o <= CONTENTS[read_addr_i];
  end

endmodule

// File: rtl/kbd_translator.sv
// Virtual-key event to ASCII translator with modifier tracking and caps lock.
// Optional typematic repeat filter: define KBD_TRANSLATOR_REPEAT_FILTER_EN.
//
// state  | meaning
// IDLE   | waiting for an event; pops the FIFO head when one is present
// LOOKUP | apply modifier / drop break, or issue the ROM read
// EMIT   | load output register, then hold it until the consumer accepts
module kbd_translator
  import kbd_translator_pkg::*;
#(
  parameter int FILTER_DEPTH = 1
) (
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic       read_valid_i,
  input  kbd_event_t read_data_i,
  output logic       read_enable_o,
  output logic [7:0] char_o,
  output logic [3:0] mods_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       caps_lock_o,
  output logic       interrupt_o
);

  kbd_state_e state_q, state_d;
  kbd_event_t ev_q;
  kbd_mods_t  mods_q, mods_now;
  logic       lshift_q, rshift_q, lctrl_q, rctrl_q, lalt_q, ralt_q, caps_q;
  logic [7:0] char_q, rom_data, emit_char;
  logic       valid_q, rom_re, letter, modifier, shift_eff, filtered;
  logic [8:0] rom_addr;

  assign mods_now.shift = lshift_q | rshift_q;
  assign mods_now.ctrl  = lctrl_q | rctrl_q;
  assign mods_now.alt   = lalt_q | ralt_q;
  assign mods_now.caps  = caps_q;

  assign letter    = is_letter(ev_q.vk);
  assign modifier  = is_modifier(ev_q.vk);
  assign shift_eff = letter ? (mods_now.shift ^ caps_q) : mods_now.shift;
  assign rom_addr  = {shift_eff, ev_q.vk};
  assign emit_char = (mods_now.ctrl && letter) ? (ev_q.vk - 8'h40) : rom_data;

`ifdef KBD_TRANSLATOR_REPEAT_FILTER_EN
  localparam int CNT_W = (FILTER_DEPTH < 1) ? 1 : $clog2(FILTER_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FILTER_DEPTH);
  logic [7:0]       last_vk_q;
  logic             last_vld_q;
  logic [CNT_W-1:0] rep_cnt_q;

  assign filtered = last_vld_q && (last_vk_q == ev_q.vk) && (rep_cnt_q < DEPTH_C);

  // Any break re-arms the filter, so the next make always gets through.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      last_vk_q  <= '0;
      last_vld_q <= 1'b0;
      rep_cnt_q  <= '0;
    end else if (state_q == LOOKUP) begin
      if (ev_q.is_break) begin
        last_vld_q <= 1'b0;
        rep_cnt_q  <= '0;
      end else if (!modifier) begin
        if (filtered) begin
          rep_cnt_q <= rep_cnt_q + CNT_W'(1);
        end else begin
          last_vk_q  <= ev_q.vk;
          last_vld_q <= 1'b1;
          rep_cnt_q  <= '0;
        end
      end
    end
  end
`else
  logic unused_filter_depth;
  assign unused_filter_depth = ^FILTER_DEPTH;
  assign filtered = 1'b0;
`endif

  kbd_translator_ascii_rom u_ascii_rom (
    .clk_i         (clk_i),
    .read_enable_i (rom_re),
    .read_addr_i   (rom_addr),
    .read_data_o   (rom_data)
  );

  always_ff @(posedge clk_i) begin
    if (!reset_ni) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    read_enable_o = 1'b0;
    rom_re        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (read_valid_i) begin
          read_enable_o = reset_ni;
          state_d       = LOOKUP;
        end
      end
      LOOKUP: begin
        if (!modifier && !ev_q.is_break && !filtered) begin
          rom_re  = 1'b1;
          state_d = EMIT;
        end else begin
          state_d = IDLE;
        end
      end
      EMIT: begin
        if (!valid_q) begin
          if (emit_char == 8'h00) state_d = IDLE;
        end else if (ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      ev_q     <= '0;
      lshift_q <= 1'b0;
      rshift_q <= 1'b0;
      lctrl_q  <= 1'b0;
      rctrl_q  <= 1'b0;
      lalt_q   <= 1'b0;
      ralt_q   <= 1'b0;
      caps_q   <= 1'b0;
      char_q   <= 8'h00;
      mods_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      if (read_enable_o) ev_q <= read_data_i;
      if (state_q == LOOKUP && modifier) begin
        case (ev_q.vk)
          VK_LSHIFT: lshift_q <= !ev_q.is_break;
          VK_RSHIFT: rshift_q <= !ev_q.is_break;
          VK_LCTRL:  lctrl_q  <= !ev_q.is_break;
          VK_RCTRL:  rctrl_q  <= !ev_q.is_break;
          VK_LALT:   lalt_q   <= !ev_q.is_break;
          VK_RALT:   ralt_q   <= !ev_q.is_break;
          VK_CAPS:   if (!ev_q.is_break) caps_q <= !caps_q;
          default: ;
        endcase
      end
      if (state_q == EMIT) begin
        if (!valid_q) begin
          if (emit_char != 8'h00) begin
            char_q  <= emit_char;
            mods_q  <= mods_now;
            valid_q <= 1'b1;
          end
        end else if (ready_i) begin
          valid_q <= 1'b0;
        end
      end
    end
  end

  assign char_o      = char_q;
  assign mods_o      = mods_q;
  assign valid_o     = valid_q;
  assign interrupt_o = valid_q;
  assign caps_lock_o = caps_q;

endmodule

// File: tb/tb_kbd_translator.sv
// Self-checking bench for kbd_translator: directed scenarios plus randomized
// event streams scored against a key-state reference model.
module tb_kbd_translator;
  import kbd_translator_pkg::*;

  localparam int FILTER_DEPTH = 1;

  logic       clk_i = 1'b0;
  logic       reset_ni = 1'b0;
  logic       read_valid_i = 1'b0;
  kbd_event_t read_data_i = '0;
  logic       read_enable_o;
  logic [7:0] char_o;
  logic [3:0] mods_o;
  logic       valid_o;
  logic       ready_i = 1'b0;
  logic       caps_lock_o;
  logic       interrupt_o;

  int n_checks = 0;
  int n_pass   = 0;

  kbd_event_t  fifo_q[$];
  logic [11:0] exp_q[$];
  logic [11:0] got_log[$];
  kbd_event_t  mon_ev;

  bit   m_down[256];
  bit   m_caps;
  int   m_last;
  int   m_drops;
  string shift_digits = ")!@#$%^&*(";

  logic [7:0] mod_vks[7]  = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'h14};
  logic [7:0] misc_vks[5] = '{8'h20, 8'h0D, 8'h08, 8'h1B, 8'h70};
  logic [7:0] rand_last = 8'h41;

  kbd_translator #(.FILTER_DEPTH(FILTER_DEPTH)) dut (
    .clk_i         (clk_i),
    .reset_ni      (reset_ni),
    .read_valid_i  (read_valid_i),
    .read_data_i   (read_data_i),
    .read_enable_o (read_enable_o),
    .char_o        (char_o),
    .mods_o        (mods_o),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .caps_lock_o   (caps_lock_o),
    .interrupt_o   (interrupt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  function automatic logic [7:0] tb_ascii(input logic [7:0] vk, input bit shifted);
    if (vk >= "A" && vk <= "Z") return shifted ? vk : vk + 8'd32;
    if (vk >= "0" && vk <= "9") return shifted ? shift_digits[vk - "0"] : vk;
    if (vk inside {8'h08, 8'h09, 8'h0D, 8'h1B, 8'h20}) return vk;
    return 8'h00;
  endfunction

  function automatic void model_reset();
    foreach (m_down[i]) m_down[i] = 1'b0;
    m_caps  = 1'b0;
    m_last  = -1;
    m_drops = 0;
    exp_q.delete();
  endfunction

  // Reference: tracks which keys are held down and predicts each output.
  function automatic void model_event(input kbd_event_t e);
    bit         is_mod, letter, sh, ct, al;
    logic [7:0] c;
    is_mod = (e.vk inside {8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'h14});
    if (is_mod) begin
      if (e.vk == 8'h14) begin
        if (!e.is_break) m_caps = !m_caps;
      end else begin
        m_down[e.vk] = !e.is_break;
      end
    end
`ifdef KBD_TRANSLATOR_REPEAT_FILTER_EN
    if (e.is_break) begin
      m_last  = -1;
      m_drops = 0;
    end
`endif
    if (is_mod || e.is_break) return;
`ifdef KBD_TRANSLATOR_REPEAT_FILTER_EN
    if (m_last == int'(e.vk) && m_drops < FILTER_DEPTH) begin
      m_drops++;
      return;
    end
    m_last  = int'(e.vk);
    m_drops = 0;
`endif
    sh = m_down[8'hA0] | m_down[8'hA1];
    ct = m_down[8'hA2] | m_down[8'hA3];
    al = m_down[8'hA4] | m_down[8'hA5];
    letter = (e.vk >= "A" && e.vk <= "Z");
    if (ct && letter) c = e.vk - 8'd64;
    else              c = tb_ascii(e.vk, letter ? (sh ^ m_caps) : sh);
    if (c != 8'h00) exp_q.push_back({c, m_caps, al, ct, sh});
  endfunction

  function automatic kbd_event_t rand_event();
    kbd_event_t e;
    int         r;
    r = int'($urandom_range(0, 9));
    if (r < 3)       e.vk = mod_vks[$urandom_range(0, 6)];
    else if (r < 5)  e.vk = rand_last;
    else if (r < 8)  e.vk = 8'h41 + 8'($urandom_range(0, 25));
    else if (r == 8) e.vk = 8'h30 + 8'($urandom_range(0, 9));
    else             e.vk = misc_vks[$urandom_range(0, 4)];
    e.is_break = ($urandom_range(0, 3) == 0);
    if (r >= 3) rand_last = e.vk;
    return e;
  endfunction

  function automatic logic [11:0] log_at(input int i);
    return (i < got_log.size()) ? got_log[i] : 12'hFFF;
  endfunction

  // FIFO head presentation (first-word fall-through), refreshed after each edge.
  always @(posedge clk_i) begin
    #1;
    read_valid_i = (fifo_q.size() != 0);
    if (fifo_q.size() != 0) read_data_i = fifo_q[0];
  end

  // Pop bookkeeping and output scoreboard, sampled mid-cycle.
  always @(negedge clk_i) begin
    if (!reset_ni) begin
      model_reset();
    end else begin
      if (read_enable_o && fifo_q.size() != 0) begin
        mon_ev = fifo_q.pop_front();
        model_event(mon_ev);
      end
      if (valid_o && ready_i) begin
        got_log.push_back({char_o, mods_o});
        chk("sb_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) chk("sb_out", {char_o, mods_o}, exp_q.pop_front());
      end
    end
  end

  task automatic push(input logic brk, input logic [7:0] vk);
    fifo_q.push_back({brk, vk});
  endtask

  task automatic wait_pop(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk_i);
      ok = read_enable_o;
    end
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk_i);
      ok = valid_o;
    end
  endtask

  task automatic drain(input string tag, input int budget);
    int quiet;
    quiet = 0;
    for (int i = 0; i < budget && quiet < 4; i++) begin
      @(negedge clk_i);
      if (fifo_q.size() == 0 && exp_q.size() == 0 && !valid_o && !read_enable_o) quiet++;
      else quiet = 0;
    end
    chk(tag, 32'(quiet >= 4), 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    model_reset();
    push(1'b1, 8'h41);
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_valid", valid_o, 0);
    chk("rst_char", char_o, 0);
    chk("rst_mods", mods_o, 0);
    chk("rst_caps", caps_lock_o, 0);
    chk("rst_irq", interrupt_o, 0);
    chk("rst_rden", read_enable_o, 0);
    @(posedge clk_i); #1 reset_ni = 1'b1;
    drain("rst_drain", 100);

    // Plain letter, exact latency from pop to valid.
    @(posedge clk_i); #1;
    ready_i = 1'b0;
    push(1'b0, 8'h41);
    wait_pop(ok);
    chk("t28_pop", ok, 1);
    repeat (2) begin
      @(negedge clk_i);
      chk("t28_early", valid_o, 0);
    end
    @(negedge clk_i);
    chk("t28_valid", valid_o, 1);
    chk("t28_char", char_o, 8'h61);
    chk("t28_mods", mods_o, 0);
    chk("t28_irq", interrupt_o, 1);
    @(posedge clk_i); #1 ready_i = 1'b1;
    @(posedge clk_i); #1 ready_i = 1'b0;
    @(negedge clk_i);
    chk("t28_fall", valid_o, 0);

    // Shift press/release ordering.
    @(posedge clk_i); #1;
    ready_i = 1'b1;
    got_log.delete();
    push(1'b1, 8'h41); push(1'b0, 8'hA0); push(1'b0, 8'h41);
    push(1'b1, 8'hA0); push(1'b0, 8'h41);
    drain("t29_drain", 200);
    chk("t29_n", got_log.size(), 2);
    chk("t29_0", log_at(0), {8'h41, 4'h1});
    chk("t29_1", log_at(1), {8'h61, 4'h0});

    // Caps lock toggling and interaction with shift.
    got_log.delete();
    push(1'b1, 8'h41); push(1'b0, 8'h14); push(1'b1, 8'h14); push(1'b0, 8'h41);
    drain("t30_drain_a", 200);
    chk("t30_caps_on", caps_lock_o, 1);
    chk("t30_0", log_at(0), {8'h41, 4'h8});
    got_log.delete();
    push(1'b1, 8'h41); push(1'b0, 8'hA1); push(1'b0, 8'h41);
    drain("t30_drain_b", 200);
    chk("t30_n", got_log.size(), 1);
    chk("t30_1", log_at(0), {8'h61, 4'h9});
    push(1'b1, 8'hA1); push(1'b0, 8'h14); push(1'b1, 8'h14);
    drain("t30_drain_c", 200);
    chk("t30_caps_off", caps_lock_o, 0);

    // Ctrl-letter with consumer stalled.
    @(posedge clk_i); #1;
    ready_i = 1'b0;
    got_log.delete();
    push(1'b1, 8'h41); push(1'b0, 8'hA2); push(1'b0, 8'h43); push(1'b0, 8'h42);
    wait_valid(ok);
    chk("t31_valid", ok, 1);
    chk("t31_char", char_o, 8'h03);
    chk("t31_mods", mods_o, 4'h2);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      chk("t31_hold_char", char_o, 8'h03);
      chk("t31_hold_valid", valid_o, 1);
      chk("t31_no_pop", read_enable_o, 0);
    end
    @(posedge clk_i); #1 ready_i = 1'b1;
    drain("t31_drain", 200);
    chk("t31_n", got_log.size(), 2);
    chk("t31_0", log_at(0), {8'h03, 4'h2});
    chk("t31_1", log_at(1), {8'h02, 4'h2});
    push(1'b1, 8'hA2);
    drain("t31_drain_b", 200);

    // Reset right after a pop discards the event and all modifier state.
    got_log.delete();
    push(1'b0, 8'h14); push(1'b0, 8'hA0);
    drain("t32_drain_a", 200);
    chk("t32_caps_set", caps_lock_o, 1);
    @(posedge clk_i); #1;
    push(1'b0, 8'h41);
    wait_pop(ok);
    chk("t32_pop", ok, 1);
    @(posedge clk_i); #1 reset_ni = 1'b0;
    @(posedge clk_i); #1 reset_ni = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      chk("t32_no_valid", valid_o, 0);
    end
    chk("t32_caps", caps_lock_o, 0);
    chk("t32_mods", mods_o, 0);
    chk("t32_char", char_o, 0);
    chk("t32_none", got_log.size(), 0);
    push(1'b0, 8'h41);
    drain("t32_drain_b", 200);
    chk("t32_n", got_log.size(), 1);
    chk("t32_clean", log_at(0), {8'h61, 4'h0});

    // Typematic repeats of the same key.
    got_log.delete();
    push(1'b1, 8'h41);
    repeat (3) push(1'b0, 8'h41);
    drain("t33_drain", 200);
`ifdef KBD_TRANSLATOR_REPEAT_FILTER_EN
    chk("t33_n", got_log.size(), 2);
`else
    chk("t33_n", got_log.size(), 3);
    chk("t33_2", log_at(2), {8'h61, 4'h0});
`endif
    chk("t33_0", log_at(0), {8'h61, 4'h0});
    chk("t33_1", log_at(1), {8'h61, 4'h0});
    push(1'b1, 8'h41);
    drain("t33_drain_b", 200);

    // Randomized traffic with random consumer backpressure.
    got_log.delete();
    for (int i = 0; i < 800; i++) begin
      @(posedge clk_i); #1;
      ready_i = ($urandom_range(0, 3) != 0);
      if (fifo_q.size() < 3 && $urandom_range(0, 1) == 1) fifo_q.push_back(rand_event());
    end
    @(posedge clk_i); #1 ready_i = 1'b1;
    drain("rand_drain", 2000);
    chk("rand_activity", 32'(got_log.size() > 20), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/kbd_translator.md
KBD_TRANSLATOR -- requirements
Module: kbd_translator

Interface
REQ-001 SHALL have parameter FILTER_DEPTH, default 1, meaning the number of consecutive identical make events dropped after the first; it is used only when the Configuration feature is compiled in.
REQ-002 SHALL have port clk_i, input, 1, the single clock.
REQ-003 SHALL have port reset_ni, input, 1; reset is synchronous and active-low.
REQ-004 SHALL have port read_valid_i, input, 1, meaning the upstream FIFO head holds an event.
REQ-005 SHALL have port read_data_i, input, 9 (kbd_event_t), carrying {is_break, vk[7:0]}; it is valid whenever read_valid_i is high (first-word fall-through).
REQ-006 SHALL have port read_enable_o, output, 1, which pops the FIFO head.
REQ-007 SHALL have port char_o, output, 8, the translated ASCII character.
REQ-008 SHALL have port mods_o, output, 4, the snapshot {caps, alt, ctrl, shift} taken with char_o.
REQ-009 SHALL have port valid_o, output, 1, meaning char_o and mods_o are valid.
REQ-010 SHALL have port ready_i, input, 1, the consumer accept signal.
REQ-011 SHALL have port caps_lock_o, output, 1, the current caps-lock state (future LED driver).
REQ-012 SHALL have port interrupt_o, output, 1, equal to valid_o.

Function
REQ-013 SHALL implement FSM states IDLE, LOOKUP, EMIT.
- IDLE with read_valid_i=1: read_enable_o=1 combinationally, event latched, next state LOOKUP.
- read_enable_o SHALL be 0 in all other cases.
REQ-014 SHALL handle modifier events in LOOKUP, updating state and emitting nothing, then return to IDLE:
- VK 0xA0/0xA1 set or clear lshift/rshift on make/break.
- VK 0xA2/0xA3 do the same for lctrl/rctrl.
- VK 0xA4/0xA5 do the same for lalt/ralt.
- VK 0x14 make toggles caps; VK 0x14 break is ignored.
REQ-015 SHALL drop non-modifier break events in LOOKUP and return to IDLE.
REQ-016 SHALL, for a non-modifier make in LOOKUP, address the ROM with {shift_eff, vk}.
- shift = lshift|rshift.
- shift_eff = shift XOR caps for VK 0x41-0x5A; shift_eff = shift otherwise.
REQ-017 SHALL, on entering EMIT, load char_o with the ROM data.
- If ctrl is held and VK is 0x41-0x5A, char_o SHALL instead be VK-0x40 (0x01-0x1A).
- A ROM result of 0x00 (non-printing) SHALL drop the event, clear valid_o and return to IDLE.
REQ-018 SHALL assert valid_o 3 cycles after the pop cycle: pop in cycle N, ROM read in N+1, output register loaded at the end of N+2, valid_o high in N+3.
REQ-019 SHALL hold char_o, mods_o and valid_o stable until ready_i=1 while valid_o=1; after the accept, valid_o SHALL fall on the next cycle and the FSM SHALL return to IDLE.
REQ-020 SHALL have at most one event in flight, with no pop outside IDLE; FIFO backpressure SHALL be provided solely by not popping.
REQ-021 SHALL apply events strictly in FIFO order; a modifier change SHALL affect only events popped after it.
REQ-022 SHALL tolerate read_valid_i rising in the same cycle as the ready_i accept; that pop SHALL occur in the following IDLE cycle.

Reset
REQ-023 SHALL, while reset_ni=0 at a clock edge:
- set the FSM to IDLE;
- clear all modifiers and caps;
- set valid_o=0, char_o=0x00, mods_o=0, read_enable_o=0, caps_lock_o=0, interrupt_o=0.
REQ-024 SHALL discard, with no pop replay, any event popped but not accepted when reset is asserted mid-operation.

Configuration
REQ-025 SHALL provide the macro KBD_TRANSLATOR_REPEAT_FILTER_EN.
- Defined: a make of the same non-modifier VK as the last make, with no intervening break of that VK, SHALL be dropped up to FILTER_DEPTH times; a count of dropped repeats SHALL be kept; the count SHALL reset on any break or different VK.
- Undefined: every make is translated (typematic repeats pass).

Structure
REQ-026 SHALL take the following from common: kbd_event_t; VK constants VK_LSHIFT, VK_RSHIFT, VK_LCTRL, VK_RCTRL, VK_LALT, VK_RALT, VK_CAPS, VK_A, VK_Z; typedef kbd_mods_t.
REQ-027 SHALL instantiate one sub-module, ascii_rom:
- 512x8, 1-cycle registered read, read_enable_i, 9-bit read_addr_i;
- CONTENTS parameter, loaded from "arom.mem" (lower half unshifted, upper half shifted).

Verification
REQ-028 SHALL cover: make 0x41 with no modifiers -> char_o=0x61, mods_o=0, valid_o high in N+3.
REQ-029 SHALL cover: make 0xA0, make 0x41, break 0xA0, make 0x41 -> chars 0x41 then 0x61, with mods_o shift=1 then 0.
REQ-030 SHALL cover:
- make 0x14, break 0x14, make 0x41 -> 0x41, caps_lock_o=1;
- then make 0xA1, make 0x41 -> 0x61.
REQ-031 SHALL cover:
- make 0xA2, make 0x43 -> char_o=0x03;
- ready_i held 0 for 10 cycles -> output stable, read_enable_o=0 throughout.
REQ-032 SHALL cover: reset_ni=0 in the cycle after a pop of 0x41 -> valid_o stays 0, caps and mods cleared, the next event translates from a clean state.
REQ-033 SHALL cover, with KBD_TRANSLATOR_REPEAT_FILTER_EN and FILTER_DEPTH=1: make 0x41 x3 -> chars emitted on the 1st and 3rd makes only; without the macro -> 3 chars.
